mci_cif_arbiter: RTL and testbench
==================================

# mci_cif_arbiter

Round-robin arbiter that shares one MCI internal CIF request path between `NUM_REQ` requesters, such as the AXI subordinate and a debug/JTAG-side master. Its single downstream port drives the MCI address decoder, which fans the transaction out to MCI registers, trace buffer, mailboxes and MCU SRAM. Each grant is locked until the downstream transaction completes. A hold-timeout watchdog aborts a hung target with an error so that a requester is never stalled indefinitely.

## Interface
- `NUM_REQ`, 2: number of requesters (2..8)
- `ADDR_W`, 32: request address width
- `DATA_W`, 32: data width; strobe width is `DATA_W/8`
- `USER_W`, 32: AXI user width
- `TIMEOUT_CYCLES`, 1024: maximum consecutive downstream hold cycles; 0 disables the watchdog
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `req_dv` in NUM_REQ: per-requester request valid
- `req_addr` in NUM_REQ*ADDR_W: packed addresses; requester i occupies slice [i*ADDR_W +: ADDR_W]
- `req_wdata` in NUM_REQ*DATA_W: packed write data
- `req_wstrb` in NUM_REQ*DATA_W/8: packed write strobes
- `req_write` in NUM_REQ: 1 = write, 0 = read
- `req_user` in NUM_REQ*USER_W: packed AXI user
- `req_hold` out NUM_REQ: per-requester hold
- `req_error` out NUM_REQ: per-requester error, valid in the completion cycle
- `req_rdata` out DATA_W: read data, broadcast to all requesters; valid only for the completing requester
- `dn_dv`, `dn_addr`, `dn_wdata`, `dn_wstrb`, `dn_write`, `dn_user` out: downstream request, same widths as a single requester
- `dn_hold`, `dn_error` in 1, `dn_rdata` in DATA_W: downstream response
- `grant_id` out $clog2(NUM_REQ): current owner
- `busy` out 1: arbiter is in BUSY
- `timeout_event` out 1: single-cycle pulse on watchdog abort

## Operation
- CIF protocol:
  - A requester holds `dv` and its request fields stable until completion.
  - Completion is the cycle with `dv & ~hold`; `rdata` and `error` are sampled in that cycle.
- IDLE:
  - `dn_dv`=0.
  - `req_hold[i]` = `req_dv[i]` for every requester.
  - If any `req_dv` is set, pick the winner: the first set bit searching upward from `last_grant+1` modulo NUM_REQ.
  - Register the winner into `grant_id`, clear the timeout counter, and go to BUSY.
- BUSY:
  - Downstream fields are muxed from requester `grant_id`; `dn_dv` = `req_dv[grant_id]`.
  - `req_hold[grant_id]` = `dn_hold`.
  - `req_error[grant_id]` = `dn_error & ~dn_hold`.
  - Every other requester with `dv` set sees `req_hold`=1 and `req_error`=0.
- BUSY exit:
  - Completion (`dn_dv & ~dn_hold`): `last_grant` ← `grant_id`, go to IDLE.
  - Requester drops `dv` before completion (protocol violation): go to IDLE; `last_grant` is not updated.
- Watchdog (TIMEOUT_CYCLES > 0):
  - The counter increments on each BUSY cycle with `dn_dv & dn_hold` and clears when `dn_hold`=0.
  - When counter == TIMEOUT_CYCLES-1 and `dn_hold`=1, that cycle is the abort cycle: `dn_dv` forced to 0, `req_hold[grant_id]`=0, `req_error[grant_id]`=1, `req_rdata`=0, `timeout_event`=1.
  - After the abort cycle: `last_grant` ← `grant_id`, go to IDLE.
- Counter width is $clog2(TIMEOUT_CYCLES+1); the counter saturates and never wraps.
- `req_rdata` = `dn_rdata` in BUSY (except the abort cycle), otherwise 0.
- Only one `dn_dv` source exists; the arbiter never issues two downstream transactions in the same cycle.

## Timing
- Reset values:
  - State IDLE.
  - `last_grant` = NUM_REQ-1, so requester 0 wins first.
  - `grant_id`=0, counter=0.
  - All outputs 0 except `req_hold`, which follows `req_dv` combinationally.
- Arbitration latency: 1 cycle. A request first seen in IDLE at cycle T is forwarded downstream at T+1.
- Minimum transaction: 2 cycles (IDLE decision, BUSY completion). There is one IDLE bubble between back-to-back grants.
- Outputs depend on registered state and combinational request inputs; there is no combinational path from `dn_hold` to `grant_id`.
- Reset asserted mid-BUSY: next cycle is IDLE with `dn_dv`=0. Downstream state is not the arbiter's responsibility.
- Simultaneous requests: resolved solely by the round-robin pointer. With all NUM_REQ requesters continuously requesting, each is granted once per NUM_REQ transactions.

## Test plan
- Single read: requester 0 reads 0x0000_0010, `dn_hold`=0 → `dn_dv` at cycle 1, completes cycle 1, `req_rdata`=`dn_rdata`, `busy` falls at cycle 2.
- Contention: NUM_REQ=2, both requesters assert `dv` at cycle 0, each with 3 back-to-back transactions → grant order 0,1,0,1,0,1; the non-owner sees `req_hold`=1 throughout.
- Hold passthrough: `dn_hold`=1 for 5 cycles, then `dn_error`=1 → owner held 5 cycles, `req_error`=1 in the completion cycle only, other `req_error` bits 0.
- Watchdog: TIMEOUT_CYCLES=8, `dn_hold` stuck at 1 → abort on the 8th hold cycle: `timeout_event` pulses for 1 cycle, `req_error`=1, `dn_dv`=0; next request is granted normally.
- `dv` drop: requester 1 deasserts `dv` mid-hold → IDLE next cycle, `last_grant` unchanged, requester 1 wins the next contention against requester 0.
- Reset mid-BUSY: assert `rst` for 1 cycle during a held transaction → all outputs at reset values, and requester 0 wins the following contention.

Source files
------------

// File: rtl/mci_cif_arbiter.sv
// Round-robin arbiter sharing one MCI CIF request path between NUM_REQ requesters.
// Grants are locked until downstream completion; a hold watchdog aborts hung targets.
module mci_cif_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned USER_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_dv,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0]  req_wstrb,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [NUM_REQ*USER_W-1:0]    req_user,
  output logic [NUM_REQ-1:0]           req_hold,
  output logic [NUM_REQ-1:0]           req_error,
  output logic [DATA_W-1:0]            req_rdata,
  output logic                         dn_dv,
  output logic [ADDR_W-1:0]            dn_addr,
  output logic [DATA_W-1:0]            dn_wdata,
  output logic [DATA_W/8-1:0]          dn_wstrb,
  output logic                         dn_write,
  output logic [USER_W-1:0]            dn_user,
  input  logic                         dn_hold,
  input  logic                         dn_error,
  input  logic [DATA_W-1:0]            dn_rdata,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  output logic                         timeout_event
);

  localparam int unsigned GW   = $clog2(NUM_REQ);
  localparam int unsigned SW   = DATA_W / 8;
  localparam int unsigned CW   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit          WdEn = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CntSat  = CW'(TIMEOUT_CYCLES);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [GW-1:0]     win_id, hi_id, lo_id;
  logic              hi_found;
  logic              sel_dv, sel_write, in_busy, abort;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [SW-1:0]     sel_wstrb;
  logic [USER_W-1:0] sel_user;

  // Winner: lowest requester above last_q, else lowest requester overall (wrap-around).
  always_comb begin
    hi_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int j = int'(NUM_REQ) - 1; j >= 0; j--) begin
      if (req_dv[j] && (j > int'(last_q))) begin
        hi_found = 1'b1;
        hi_id    = GW'(j);
      end
      if (req_dv[j]) begin
        lo_id = GW'(j);
      end
    end
    win_id = hi_found ? hi_id : lo_id;
  end

  // Select the current owner's request fields.
  always_comb begin
    sel_dv    = 1'b0;
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    sel_user  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_q == GW'(i)) begin
        sel_dv    = req_dv[i];
        sel_write = req_write[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_wstrb = req_wstrb[i*SW +: SW];
        sel_user  = req_user[i*USER_W +: USER_W];
      end
    end
  end

  // Downstream and per-requester response outputs.
  always_comb begin
    in_busy       = (state_q == StBusy);
    abort         = WdEn && in_busy && sel_dv && dn_hold && (cnt_q == CntLast);
    dn_dv         = in_busy && sel_dv && !abort;
    dn_addr       = in_busy ? sel_addr : '0;
    dn_wdata      = in_busy ? sel_wdata : '0;
    dn_wstrb      = in_busy ? sel_wstrb : '0;
    dn_write      = in_busy && sel_write;
    dn_user       = in_busy ? sel_user : '0;
    req_rdata     = (in_busy && !abort) ? dn_rdata : '0;
    busy          = in_busy;
    grant_id      = grant_q;
    timeout_event = abort;
    // Non-owners with a pending request are always held.
    req_hold      = req_dv;
    req_error     = '0;
    if (in_busy) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (grant_q == GW'(i)) begin
          req_hold[i]  = sel_dv && dn_hold && !abort;
          req_error[i] = abort || (dn_error && !dn_hold);
        end
      end
    end
  end

  // Next-state: grant decision in idle, completion/abort/drop handling in busy.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (|req_dv) begin
          grant_d = win_id;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      default: begin
        if (abort || (dn_dv && !dn_hold)) begin
          last_d  = grant_q;
          state_d = StIdle;
        end else if (!sel_dv) begin
          // Requester abandoned the transfer: leave the round-robin pointer alone.
          state_d = StIdle;
        end
        if (!dn_hold) begin
          cnt_d = '0;
        end else if (sel_dv && (cnt_q != CntSat)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= GW'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mci_cif_arbiter.sv
// Directed table-driven bench for mci_cif_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=8).
module tb_mci_cif_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_dv;
  logic [63:0] req_addr, req_wdata, req_user;
  logic [7:0]  req_wstrb;
  logic [1:0]  req_write;
  logic [1:0]  req_hold, req_error;
  logic [31:0] req_rdata;
  logic        dn_dv, dn_write, dn_hold, dn_error;
  logic [31:0] dn_addr, dn_wdata, dn_user, dn_rdata;
  logic [3:0]  dn_wstrb;
  logic        grant_id, busy, timeout_event;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mci_cif_arbiter #(
    .NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .USER_W(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .req_dv(req_dv), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .req_write(req_write), .req_user(req_user),
    .req_hold(req_hold), .req_error(req_error), .req_rdata(req_rdata),
    .dn_dv(dn_dv), .dn_addr(dn_addr), .dn_wdata(dn_wdata), .dn_wstrb(dn_wstrb),
    .dn_write(dn_write), .dn_user(dn_user), .dn_hold(dn_hold), .dn_error(dn_error),
    .dn_rdata(dn_rdata), .grant_id(grant_id), .busy(busy), .timeout_event(timeout_event)
  );

  typedef struct {
    logic        rst;
    logic        chk;
    logic [1:0]  dv;
    logic        hold;
    logic        err;
    logic [31:0] rd;
    logic        e_dndv;
    logic [1:0]  e_rhold;
    logic [1:0]  e_rerr;
    logic        e_gid;
    logic        e_busy;
    logic        e_tev;
    logic [31:0] e_rrd;
    logic [31:0] e_daddr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic c, input logic [1:0] dv, input logic h,
                     input logic e, input logic [31:0] rd, input logic edv,
                     input logic [1:0] erh, input logic [1:0] ere, input logic eg,
                     input logic eb, input logic et, input logic [31:0] err_d,
                     input logic [31:0] ea);
    vec_t v;
    v.rst = r; v.chk = c; v.dv = dv; v.hold = h; v.err = e; v.rd = rd;
    v.e_dndv = edv; v.e_rhold = erh; v.e_rerr = ere; v.e_gid = eg; v.e_busy = eb;
    v.e_tev = et; v.e_rrd = err_d; v.e_daddr = ea;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d actual %h required %h", nm, row, act, exp);
    end
  endtask

  // Owner write data / write flag implied by the owner's address.
  function automatic logic [31:0] exp_wdata(input logic [31:0] a);
    if (a == 32'h10) return 32'hA0;
    if (a == 32'h20) return 32'hB1;
    return 32'h0;
  endfunction

  int cnt0, cnt1, done;
  logic prev_gid;
  logic have_prev;

  initial begin
    rst       = 1'b1;
    req_dv    = 2'b00;
    req_addr  = {32'h20, 32'h10};
    req_wdata = {32'hB1, 32'hA0};
    req_wstrb = {4'hF, 4'h3};
    req_write = 2'b10;
    req_user  = {32'h2, 32'h1};
    dn_hold   = 1'b0;
    dn_error  = 1'b0;
    dn_rdata  = 32'h0;

    // Reset state.
    add(0,1,2'b00,0,0,32'h0,  0,2'b00,2'b00,0,0,0,32'h0,32'h0);
    // Single read by requester 0.
    add(0,1,2'b01,0,0,32'hAA, 0,2'b01,2'b00,0,0,0,32'h0,32'h0);
    add(0,1,2'b01,0,0,32'hAA, 1,2'b00,2'b00,0,1,0,32'hAA,32'h10);
    add(0,1,2'b00,0,0,32'hAA, 0,2'b00,2'b00,0,0,0,32'h0,32'h0);
    add(1,0,2'b00,0,0,32'h0,  0,2'b00,2'b00,0,0,0,32'h0,32'h0);
    // Contention, three transactions each: grants 0,1,0,1,0,1.
    for (int k = 0; k < 3; k++) begin
      add(0,1,2'b11,0,0,32'hC3, 0,2'b11,2'b00,(k != 0),0,0,32'h0,32'h0);
      add(0,1,2'b11,0,0,32'hC3, 1,2'b10,2'b00,0,1,0,32'hC3,32'h10);
      add(0,1,2'b11,0,0,32'hC3, 0,2'b11,2'b00,0,0,0,32'h0,32'h0);
      add(0,1,2'b11,0,0,32'hC3, 1,2'b01,2'b00,1,1,0,32'hC3,32'h20);
    end
    add(0,1,2'b00,0,0,32'hC3, 0,2'b00,2'b00,1,0,0,32'h0,32'h0);
    // Hold passthrough: 5 held cycles then error completion; requester 1 waiting.
    add(0,1,2'b01,1,1,32'h55, 0,2'b01,2'b00,1,0,0,32'h0,32'h0);
    for (int k = 0; k < 5; k++)
      add(0,1,2'b11,1,1,32'h55, 1,2'b11,2'b00,0,1,0,32'h55,32'h10);
    add(0,1,2'b11,0,1,32'h55, 1,2'b10,2'b01,0,1,0,32'h55,32'h10);
    add(0,1,2'b10,0,0,32'h55, 0,2'b10,2'b00,0,0,0,32'h0,32'h0);
    add(0,1,2'b10,0,0,32'h55, 1,2'b00,2'b00,1,1,0,32'h55,32'h20);
    add(0,1,2'b00,0,0,32'h55, 0,2'b00,2'b00,1,0,0,32'h0,32'h0);
    // Watchdog: dn_hold stuck, abort on the 8th held cycle.
    add(0,1,2'b01,1,0,32'h77, 0,2'b01,2'b00,1,0,0,32'h0,32'h0);
    for (int k = 0; k < 7; k++)
      add(0,1,2'b01,1,0,32'h77, 1,2'b01,2'b00,0,1,0,32'h77,32'h10);
    add(0,1,2'b01,1,0,32'h77, 0,2'b00,2'b01,0,1,1,32'h0,32'h10);
    add(0,1,2'b00,1,0,32'h77, 0,2'b00,2'b00,0,0,0,32'h0,32'h0);
    add(0,1,2'b01,0,0,32'h77, 0,2'b01,2'b00,0,0,0,32'h0,32'h0);
    add(0,1,2'b01,0,0,32'h77, 1,2'b00,2'b00,0,1,0,32'h77,32'h10);
    add(0,1,2'b00,0,0,32'h77, 0,2'b00,2'b00,0,0,0,32'h0,32'h0);
    // dv drop by requester 1 mid-hold; pointer unchanged so it wins again.
    add(0,1,2'b10,1,0,32'h99, 0,2'b10,2'b00,0,0,0,32'h0,32'h0);
    add(0,1,2'b10,1,0,32'h99, 1,2'b10,2'b00,1,1,0,32'h99,32'h20);
    add(0,1,2'b00,1,0,32'h99, 0,2'b00,2'b00,1,1,0,32'h99,32'h20);
    add(0,1,2'b11,0,0,32'h99, 0,2'b11,2'b00,1,0,0,32'h0,32'h0);
    add(0,1,2'b11,0,0,32'h99, 1,2'b01,2'b00,1,1,0,32'h99,32'h20);
    add(0,1,2'b01,0,0,32'h99, 0,2'b01,2'b00,1,0,0,32'h0,32'h0);
    add(0,1,2'b01,0,0,32'h99, 1,2'b00,2'b00,0,1,0,32'h99,32'h10);
    add(0,1,2'b00,0,0,32'h99, 0,2'b00,2'b00,0,0,0,32'h0,32'h0);
    // Reset mid-busy while requester 1 owns; requester 0 then wins contention.
    add(0,1,2'b10,1,0,32'hEE, 0,2'b10,2'b00,0,0,0,32'h0,32'h0);
    add(0,1,2'b10,1,0,32'hEE, 1,2'b10,2'b00,1,1,0,32'hEE,32'h20);
    add(1,0,2'b10,1,0,32'hEE, 0,2'b00,2'b00,0,0,0,32'h0,32'h0);
    add(0,1,2'b00,0,0,32'hEE, 0,2'b00,2'b00,0,0,0,32'h0,32'h0);
    add(0,1,2'b11,0,0,32'hEE, 0,2'b11,2'b00,0,0,0,32'h0,32'h0);
    add(0,1,2'b11,0,0,32'hEE, 1,2'b10,2'b00,0,1,0,32'hEE,32'h10);
    add(0,1,2'b00,0,0,32'hEE, 0,2'b00,2'b00,0,0,0,32'h0,32'h0);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Each row: drive after the edge, check mid-cycle, then advance one clock.
    foreach (vecs[r]) begin
      rst      = vecs[r].rst;
      req_dv   = vecs[r].dv;
      dn_hold  = vecs[r].hold;
      dn_error = vecs[r].err;
      dn_rdata = vecs[r].rd;
      #1;
      if (vecs[r].chk) begin
        check("dn_dv",     r, 32'(dn_dv),         32'(vecs[r].e_dndv));
        check("req_hold",  r, 32'(req_hold),      32'(vecs[r].e_rhold));
        check("req_error", r, 32'(req_error),     32'(vecs[r].e_rerr));
        check("grant_id",  r, 32'(grant_id),      32'(vecs[r].e_gid));
        check("busy",      r, 32'(busy),          32'(vecs[r].e_busy));
        check("timeout",   r, 32'(timeout_event), 32'(vecs[r].e_tev));
        check("req_rdata", r, req_rdata,          vecs[r].e_rrd);
        check("dn_addr",   r, dn_addr,            vecs[r].e_daddr);
        check("dn_wdata",  r, dn_wdata,           exp_wdata(vecs[r].e_daddr));
        check("dn_write",  r, 32'(dn_write),      32'(vecs[r].e_daddr == 32'h20));
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;

    // Fairness: both requesting continuously, six completions alternate 1,0,1,0,1,0.
    req_dv    = 2'b11;
    dn_hold   = 1'b0;
    dn_error  = 1'b0;
    cnt0      = 0;
    cnt1      = 0;
    done      = 0;
    have_prev = 1'b0;
    prev_gid  = 1'b0;
    for (int cyc = 0; cyc < 40 && done < 6; cyc++) begin
      #1;
      if (dn_dv && !dn_hold) begin
        if (have_prev) check("fair_alternate", done, 32'(grant_id), 32'(!prev_gid));
        else           check("fair_first", done, 32'(grant_id), 32'd1);
        if (grant_id) cnt1++;
        else          cnt0++;
        prev_gid  = grant_id;
        have_prev = 1'b1;
        done++;
      end
      @(posedge clk);
    end
    check("fair_budget", 0, 32'(done), 32'd6);
    check("fair_cnt0",   0, 32'(cnt0), 32'd3);
    check("fair_cnt1",   0, 32'(cnt1), 32'd3);
    req_dv = 2'b00;
    @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
